// File: rtl/miriscv_uart_tx.sv
// miriscv SoC UART transmitter: byte FIFO feeding an 8E1 serialiser
// (start, 8 data bits LSB first, even parity, stop); line idles high.
module miriscv_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 128,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [7:0]       head;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             bit_done;

  assign fifo_full  = (level_q == LVL_FULL);
  assign fifo_empty = (level_q == '0);
  assign tx_ready_o = !fifo_full;
  assign push       = tx_valid_i && !fifo_full;
  assign head       = fifo_mem[rd_ptr_q];
  assign bit_done   = (timer_q == CNT_LAST);

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= tx_data_i;
  end

  // Frame sequencer; every line change is produced at a bit-timer wrap.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    if (state_q != S_IDLE) timer_d = bit_done ? '0 : timer_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = head;
          parity_d = ^head;
          tx_d     = 1'b0;
          timer_d  = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
            tx_d    = parity_q;
            state_d = S_PARITY;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            shift_d  = head;
            parity_d = ^head;
            tx_d     = 1'b0;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase

    // Drops on the edge that completes a stop bit with nothing left queued.
    busy_d = (state_d != S_IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;

endmodule
